// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared constants, state enum and address-field helpers for icache
package icache_pkg;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [2:0] SIZE_4B     = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_MISS_AR,
        ST_MISS_R,
        ST_RESP
    } state_t;

    // Word-offset field width within a line
    function automatic int off_w(input int line_words);
        return $clog2(line_words);
    endfunction

    // Set-index field width
    function automatic int idx_w(input int nsets);
        return $clog2(nsets);
    endfunction

    // Tag width: whatever remains above index, offset and byte bits
    function automatic int tag_w(input int nsets, input int line_words);
        return 32 - 2 - $clog2(line_words) - $clog2(nsets);
    endfunction

endpackage

// File: rtl/icache_data_array.sv
// rtl/icache_data_array.sv - line data storage, one sync write port, one combinational read port
module icache_data_array
    import icache_pkg::*;
#(
    parameter int NSETS      = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic                          clk,
    input  logic                          wen,
    input  logic [idx_w(NSETS)-1:0]       wr_idx,
    input  logic [off_w(LINE_WORDS)-1:0]  wr_word,
    input  logic [31:0]                   wr_data,
    input  logic [idx_w(NSETS)-1:0]       rd_idx,
    input  logic [off_w(LINE_WORDS)-1:0]  rd_word,
    output logic [31:0]                   rd_data
);

    logic [31:0] mem [NSETS*LINE_WORDS];

    // Refill beats land here one word per cycle
    always_ff @(posedge clk) begin
        if (wen) begin
            mem[{wr_idx, wr_word}] <= wr_data;
        end
    end

    // Lookup reads the addressed word without waiting a cycle
    always_comb begin
        rd_data = mem[{rd_idx, rd_word}];
    end

endmodule

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped read-only instruction cache; ICACHE_FENCEI_EN adds fence_i invalidation
module icache
    import icache_pkg::*;
#(
    parameter int NSETS      = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_arvalid,
    output logic        s_arready,
    input  logic [31:0] s_araddr,
    input  logic [3:0]  s_arid,
    input  logic [7:0]  s_arlen,
    input  logic [2:0]  s_arsize,
    input  logic [1:0]  s_arburst,
    output logic        s_rvalid,
    input  logic        s_rready,
    output logic [31:0] s_rdata,
    output logic [1:0]  s_rresp,
    output logic        s_rlast,
    output logic [3:0]  s_rid,
    output logic        m_arvalid,
    input  logic        m_arready,
    output logic [31:0] m_araddr,
    output logic [3:0]  m_arid,
    output logic [7:0]  m_arlen,
    output logic [2:0]  m_arsize,
    output logic [1:0]  m_arburst,
    input  logic        m_rvalid,
    output logic        m_rready,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp,
    input  logic        m_rlast,
`ifdef ICACHE_FENCEI_EN
    input  logic        fence_i,
`endif
    input  logic [3:0]  m_rid
);

    localparam int OFF_W = off_w(LINE_WORDS);
    localparam int IDX_W = idx_w(NSETS);
    localparam int TAG_W = tag_w(NSETS, LINE_WORDS);
    localparam int LO_W  = OFF_W + 2;

    state_t              state_q, state_d;
    logic [31:0]         addr_q;
    logic [OFF_W-1:0]    cnt_q;
    logic                err_q;
    logic [31:0]         rdata_q;
    logic [NSETS-1:0]    valid_q;
    logic [TAG_W-1:0]    tag_q [NSETS];

    logic [OFF_W-1:0]    addr_off;
    logic [IDX_W-1:0]    addr_idx;
    logic [TAG_W-1:0]    addr_tag;
    logic                hit;
    logic                beat;
    logic                err_next;
    logic                fence_clear;
    logic [31:0]         rd_word;

    assign addr_off = addr_q[LO_W-1:2];
    assign addr_idx = addr_q[LO_W+IDX_W-1:LO_W];
    assign addr_tag = addr_q[31:LO_W+IDX_W];
    assign hit      = valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag);
    assign beat     = (state_q == ST_MISS_R) && m_rvalid;
    assign err_next = err_q | (|m_rresp);

`ifdef ICACHE_FENCEI_EN
    logic fence_pend_q;

    // A fence seen while busy waits for the next IDLE cycle
    assign fence_clear = (state_q == ST_IDLE) && (fence_i || fence_pend_q);

    // Remember fences that arrive outside IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            fence_pend_q <= 1'b0;
        end else if (fence_clear) begin
            fence_pend_q <= 1'b0;
        end else if (fence_i) begin
            fence_pend_q <= 1'b1;
        end
    end
`else
    assign fence_clear = 1'b0;
`endif

    icache_data_array #(
        .NSETS      (NSETS),
        .LINE_WORDS (LINE_WORDS)
    ) u_data (
        .clk     (clk),
        .wen     (beat),
        .wr_idx  (addr_idx),
        .wr_word (cnt_q),
        .wr_data (m_rdata),
        .rd_idx  (addr_idx),
        .rd_word (addr_off),
        .rd_data (rd_word)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and state-decoded handshake outputs
    always_comb begin
        state_d   = state_q;
        s_arready = 1'b0;
        m_arvalid = 1'b0;
        m_rready  = 1'b0;
        s_rvalid  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                s_arready = !rst && !fence_clear;
                if (s_arvalid && s_arready) begin
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                state_d = hit ? ST_RESP : ST_MISS_AR;
            end
            ST_MISS_AR: begin
                m_arvalid = 1'b1;
                if (m_arready) begin
                    state_d = ST_MISS_R;
                end
            end
            ST_MISS_R: begin
                m_rready = 1'b1;
                if (m_rvalid && m_rlast) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                s_rvalid = 1'b1;
                if (s_rready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Request latch, response word, refill counter, error flag and line valid bits
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            valid_q <= '0;
        end else begin
            if (fence_clear) begin
                valid_q <= '0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (s_arvalid && s_arready) begin
                        addr_q <= s_araddr;
                    end
                end
                ST_LOOKUP: begin
                    if (hit) begin
                        rdata_q <= rd_word;
                    end
                end
                ST_MISS_R: begin
                    if (m_rvalid) begin
                        cnt_q <= cnt_q + 1'b1;
                        err_q <= err_next;
                        if (cnt_q == addr_off) begin
                            rdata_q <= m_rdata;
                        end
                        if (m_rlast && !err_next) begin
                            valid_q[addr_idx] <= 1'b1;
                        end
                    end
                end
                ST_RESP: begin
                    if (s_rready) begin
                        cnt_q <= '0;
                        err_q <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Tags need no reset; they only matter once the valid bit is set
    always_ff @(posedge clk) begin
        if (beat && m_rlast && !err_next) begin
            tag_q[addr_idx] <= addr_tag;
        end
    end

    assign s_rdata   = rdata_q;
    assign s_rresp   = err_q ? RESP_SLVERR : RESP_OKAY;
    assign s_rlast   = s_rvalid;
    assign s_rid     = 4'd0;
    assign m_araddr  = {addr_q[31:LO_W], {LO_W{1'b0}}};
    assign m_arid    = 4'd0;
    assign m_arlen   = 8'(LINE_WORDS - 1);
    assign m_arsize  = SIZE_4B;
    assign m_arburst = BURST_INCR;

    logic unused_inputs;
    assign unused_inputs = ^{s_arid, s_arlen, s_arsize, s_arburst, m_rid, addr_q[1:0]};

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - directed self-checking bench for icache
module tb_icache;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_arvalid;
    logic        s_arready;
    logic [31:0] s_araddr;
    logic        s_rvalid;
    logic        s_rready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rlast;
    logic [3:0]  s_rid;
    logic        m_arvalid;
    logic        m_arready;
    logic [31:0] m_araddr;
    logic [3:0]  m_arid;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arsize;
    logic [1:0]  m_arburst;
    logic        m_rvalid;
    logic        m_rready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rlast;
    logic        fence_i;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    icache #(.NSETS(16), .LINE_WORDS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_araddr  (s_araddr),
        .s_arid    (4'd0),
        .s_arlen   (8'd0),
        .s_arsize  (3'b010),
        .s_arburst (2'b00),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rlast   (s_rlast),
        .s_rid     (s_rid),
        .m_arvalid (m_arvalid),
        .m_arready (m_arready),
        .m_araddr  (m_araddr),
        .m_arid    (m_arid),
        .m_arlen   (m_arlen),
        .m_arsize  (m_arsize),
        .m_arburst (m_arburst),
        .m_rvalid  (m_rvalid),
        .m_rready  (m_rready),
        .m_rdata   (m_rdata),
        .m_rresp   (m_rresp),
        .m_rlast   (m_rlast),
`ifdef ICACHE_FENCEI_EN
        .fence_i   (fence_i),
`endif
        .m_rid     (4'd0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One fetch from accept to response handshake; inputs change and outputs are sampled on negedge
    task automatic fetch(input string tag, input logic [31:0] addr, input bit exp_miss,
                         input logic [3:0][31:0] bdata, input logic [3:0][1:0] bresp,
                         input logic [31:0] exp_data, input logic [1:0] exp_resp,
                         input int hold, input bit pulse_fence);
        @(negedge clk);
        check({tag, ".arready_idle"}, 32'(s_arready), 32'd1);
        s_araddr  = addr;
        s_arvalid = 1'b1;
        @(negedge clk);
        s_arvalid = 1'b0;
        check({tag, ".arready_busy"}, 32'(s_arready), 32'd0);
        @(negedge clk);
        if (!exp_miss) begin
            check({tag, ".hit_rvalid_t2"}, 32'(s_rvalid), 32'd1);
            check({tag, ".hit_no_arvalid"}, 32'(m_arvalid), 32'd0);
        end else begin
            check({tag, ".miss_arvalid_t2"}, 32'(m_arvalid), 32'd1);
            check({tag, ".miss_rvalid_t2"}, 32'(s_rvalid), 32'd0);
            check({tag, ".m_araddr"}, m_araddr, addr & 32'hFFFF_FFF0);
            check({tag, ".m_arlen"}, 32'(m_arlen), 32'd3);
            check({tag, ".m_arburst_size"}, {27'd0, m_arburst, m_arsize}, {27'd0, 2'b01, 3'b010});
            m_arready = 1'b1;
            @(negedge clk);
            m_arready = 1'b0;
            check({tag, ".m_rready"}, 32'(m_rready), 32'd1);
            for (int i = 0; i < 4; i++) begin
                m_rvalid = 1'b1;
                m_rdata  = bdata[i];
                m_rresp  = bresp[i];
                m_rlast  = (i == 3);
                fence_i  = pulse_fence && (i == 1);
                @(negedge clk);
                fence_i  = 1'b0;
            end
            m_rvalid = 1'b0;
            m_rlast  = 1'b0;
            m_rresp  = 2'b00;
            check({tag, ".rvalid_after_last"}, 32'(s_rvalid), 32'd1);
        end
        check({tag, ".rdata"}, s_rdata, exp_data);
        check({tag, ".rresp"}, 32'(s_rresp), 32'(exp_resp));
        check({tag, ".rlast_rid"}, {27'd0, s_rlast, s_rid}, {27'd0, 1'b1, 4'd0});
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check({tag, ".stall_rvalid"}, 32'(s_rvalid), 32'd1);
            check({tag, ".stall_rdata"}, s_rdata, exp_data);
            check({tag, ".stall_arready"}, 32'(s_arready), 32'd0);
        end
        s_rready = 1'b1;
        @(negedge clk);
        s_rready = 1'b0;
        check({tag, ".rvalid_drop"}, 32'(s_rvalid), 32'd0);
        check({tag, ".arready_after"}, 32'(s_arready), pulse_fence ? 32'd0 : 32'd1);
    endtask

    localparam logic [3:0][1:0] OK4 = '0;

    initial begin
        rst       = 1'b1;
        s_arvalid = 1'b0;
        s_araddr  = '0;
        s_rready  = 1'b0;
        m_arready = 1'b0;
        m_rvalid  = 1'b0;
        m_rdata   = '0;
        m_rresp   = '0;
        m_rlast   = 1'b0;
        fence_i   = 1'b0;

        @(negedge clk);
        @(negedge clk);
        check("rst.arready", 32'(s_arready), 32'd0);
        check("rst.handshakes", {29'd0, s_rvalid, m_arvalid, m_rready}, 32'd0);
        check("rst.rdata", s_rdata, 32'd0);
        check("rst.rresp", 32'(s_rresp), 32'd0);
        rst = 1'b0;

        // cold miss, offset 1
        fetch("cold", 32'h8000_0004, 1'b1, {32'h44, 32'h33, 32'h22, 32'h11}, OK4,
              32'h22, 2'b00, 0, 1'b0);
        // hit in the just-filled line
        fetch("hit", 32'h8000_000C, 1'b0, '0, OK4, 32'h44, 2'b00, 0, 1'b0);
        // same index, different tag evicts
        fetch("conflict", 32'h8000_0100, 1'b1, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, OK4,
              32'hA0, 2'b00, 0, 1'b0);
        fetch("refetch", 32'h8000_0000, 1'b1, {32'h44, 32'h33, 32'h22, 32'h11}, OK4,
              32'h11, 2'b00, 0, 1'b0);
        // error on beat 2 reports SLVERR and leaves the line invalid
        fetch("err", 32'h8000_0028, 1'b1, {32'h88, 32'h77, 32'h66, 32'h55},
              {2'b00, 2'b10, 2'b00, 2'b00}, 32'h77, 2'b10, 0, 1'b0);
        fetch("err_retry", 32'h8000_0028, 1'b1, {32'h98, 32'h97, 32'h96, 32'h95}, OK4,
              32'h97, 2'b00, 0, 1'b0);
        fetch("err_hit", 32'h8000_0024, 1'b0, '0, OK4, 32'h96, 2'b00, 0, 1'b0);
        // response held by IFU back-pressure
        fetch("stall", 32'h8000_0000, 1'b0, '0, OK4, 32'h11, 2'b00, 5, 1'b0);

`ifdef ICACHE_FENCEI_EN
        fetch("fence_fill", 32'h8000_0040, 1'b1, {32'hC3, 32'hC2, 32'hC1, 32'hC0}, OK4,
              32'hC0, 2'b00, 0, 1'b1);
        fetch("fence_after", 32'h8000_0000, 1'b1, {32'h44, 32'h33, 32'h22, 32'h11}, OK4,
              32'h11, 2'b00, 0, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
